// File: rtl/rti_event_dispatcher.sv
// Pops timestamped events from the RTI_Core FIFO and releases each as a 1-cycle strobe once current_time reaches its timestamp.
// Fires the cycle after current_time == ts; one event in flight, so no FIFO pop is requested outside IDLE.
`timescale 1ns/1ps
module rti_event_dispatcher #(
    parameter logic [63:0] LATE_TOLERANCE = 64'd0,
    parameter int unsigned COUNT_WIDTH    = 32
) (
    input  logic                   rd_clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [63:0]            current_time,
    input  logic                   fifo_empty,
    output logic                   fifo_read,
    input  logic [127:0]           fifo_dout,
    output logic                   out_valid,
    output logic [63:0]            out_data,
    output logic                   late_error,
    output logic [127:0]           late_error_data,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] event_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [63:0]            r_ts_hold;
    logic [63:0]            r_data_hold;
    logic                   r_out_valid;
    logic [63:0]            r_out_data;
    logic                   r_late_error;
    logic [127:0]           r_late_error_data;
    logic [COUNT_WIDTH-1:0] r_event_count;

    logic                   w_pop;
    logic [63:0]            w_load_ts;
    logic [64:0]            w_deadline_sum;
    logic [63:0]            w_deadline;
    logic                   w_late;
    logic                   w_due;

    // Reset is folded in so a pop can never be requested while the FSM is being forced to IDLE.
    assign w_pop     = (r_state == S_IDLE) & ~fifo_empty & ~flush & ~reset;
    assign fifo_read = w_pop;

    // Deadline saturates at all-ones so timestamps near the top of the range are never misjudged late.
    assign w_load_ts      = fifo_dout[127:64];
    assign w_deadline_sum = {1'b0, w_load_ts} + {1'b0, LATE_TOLERANCE};
    assign w_deadline     = w_deadline_sum[64] ? {64{1'b1}} : w_deadline_sum[63:0];
    assign w_late         = current_time > w_deadline;
    assign w_due          = current_time >= r_ts_hold;

    always_ff @(posedge rd_clk or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_ts_hold         <= '0;
            r_data_hold       <= '0;
            r_out_valid       <= 1'b0;
            r_out_data        <= '0;
            r_late_error      <= 1'b0;
            r_late_error_data <= '0;
            r_event_count     <= '0;
        end else if (flush) begin
            r_state           <= S_IDLE;
            r_ts_hold         <= '0;
            r_data_hold       <= '0;
            r_out_valid       <= 1'b0;
            r_out_data        <= '0;
            r_late_error      <= 1'b0;
            r_late_error_data <= '0;
            r_event_count     <= '0;
        end else begin
            r_out_valid  <= 1'b0;
            r_late_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_ts_hold   <= w_load_ts;
                    r_data_hold <= fifo_dout[63:0];
                    if (w_late) begin
                        r_late_error      <= 1'b1;
                        r_late_error_data <= fifo_dout;
                        r_state           <= S_IDLE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_due) begin
                        r_out_valid   <= 1'b1;
                        r_out_data    <= r_data_hold;
                        r_event_count <= r_event_count + CNT_ONE;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign late_error      = r_late_error;
    assign late_error_data = r_late_error_data;
    assign busy            = (r_state != S_IDLE);
    assign event_count     = r_event_count;

endmodule
